// File: rtl/usr_irq_pkg.sv
// usr_irq_pkg: register map, STATUS bit positions and read-FSM encoding
// shared by the user-interrupt slave and its sub-modules.
package usr_irq_pkg;

    localparam int unsigned ADDR_TRIGGER   = 0;
    localparam int unsigned ADDR_STATUS    = 1;
    localparam int unsigned ADDR_ENABLE    = 2;
    localparam int unsigned ADDR_COUNT     = 3;
    localparam int unsigned ADDR_TIMESTAMP = 4;

    localparam int unsigned ST_PEND = 0;
    localparam int unsigned ST_OVF  = 1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/usr_irq_sat_cnt.sv
// usr_irq_sat_cnt: W-bit saturating up-counter; clr wins over inc.
// Ports: clk, rst_n (async low), clr, inc, count[W-1:0].
module usr_irq_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/usr_irq_slave.sv
// usr_irq_slave: Avalon-MM slave turning event writes into a level IRQ.
// Ports: clk, rst_n, irq_avalon_slave_* (cs/addr/rd/wr/wd/wait/rdata), irq_out.
// Optional macro USR_IRQ_TIMESTAMP_EN adds a TIMESTAMP register at word 4.
module usr_irq_slave
    import usr_irq_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq_avalon_slave_chipselect,
    input  logic [ADDR_W-1:0] irq_avalon_slave_address,
    input  logic              irq_avalon_slave_read,
    input  logic              irq_avalon_slave_write,
    input  logic [31:0]       irq_avalon_slave_writedata,
    output logic              irq_avalon_slave_waitrequest,
    output logic [31:0]       irq_avalon_slave_readdata,
    output logic              irq_out
);

    logic             rd_ok;
    logic             wr_ok;
    logic             sel_trig;
    logic             sel_stat;
    logic             sel_en;
    logic             sel_cnt;
    logic             ev;
    logic             pending;
    logic             overflow;
    logic             enable;
    logic [CNT_W-1:0] count;
    logic [31:0]      rd_mux;
    rd_state_t        state;
    logic             unused;

    // Both strobes high at once is not a legal access and is dropped.
    assign rd_ok = irq_avalon_slave_chipselect & irq_avalon_slave_read
                 & ~irq_avalon_slave_write;
    assign wr_ok = irq_avalon_slave_chipselect & irq_avalon_slave_write
                 & ~irq_avalon_slave_read;

    assign sel_trig = irq_avalon_slave_address == ADDR_W'(ADDR_TRIGGER);
    assign sel_stat = irq_avalon_slave_address == ADDR_W'(ADDR_STATUS);
    assign sel_en   = irq_avalon_slave_address == ADDR_W'(ADDR_ENABLE);
    assign sel_cnt  = irq_avalon_slave_address == ADDR_W'(ADDR_COUNT);

    assign ev = wr_ok & sel_trig & irq_avalon_slave_writedata[0];

    assign unused = ^irq_avalon_slave_writedata[31:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            overflow <= 1'b0;
            enable   <= 1'b0;
            irq_out  <= 1'b0;
        end else begin
            if (ev) begin
                pending <= 1'b1;
                if (pending) overflow <= 1'b1;
            end else if (wr_ok && sel_stat) begin
                if (irq_avalon_slave_writedata[ST_PEND]) pending  <= 1'b0;
                if (irq_avalon_slave_writedata[ST_OVF])  overflow <= 1'b0;
            end
            if (wr_ok && sel_en) enable <= irq_avalon_slave_writedata[0];
            irq_out <= pending & enable;
        end
    end

    usr_irq_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wr_ok & sel_cnt),
        .inc   (ev),
        .count (count)
    );

`ifdef USR_IRQ_TIMESTAMP_EN
    logic            sel_ts;
    logic [TS_W-1:0] ts_free;
    logic [TS_W-1:0] ts_q;

    assign sel_ts = irq_avalon_slave_address == ADDR_W'(ADDR_TIMESTAMP);

    // Only the first event of a pending burst is timestamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_free <= '0;
            ts_q    <= '0;
        end else begin
            ts_free <= ts_free + TS_W'(1);
            if (ev && !pending) ts_q <= ts_free;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_trig: rd_mux[0] = pending;
            sel_stat: begin
                rd_mux[ST_PEND] = pending;
                rd_mux[ST_OVF]  = overflow;
            end
            sel_en:   rd_mux[0] = enable;
            sel_cnt:  rd_mux = 32'(count);
`ifdef USR_IRQ_TIMESTAMP_EN
            sel_ts:   rd_mux = 32'(ts_q);
`endif
            default:  rd_mux = '0;
        endcase
    end

    // One wait cycle in R_IDLE; data is presented in R_ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= R_IDLE;
            irq_avalon_slave_readdata <= '0;
        end else begin
            unique case (state)
                R_IDLE: begin
                    if (rd_ok) begin
                        irq_avalon_slave_readdata <= rd_mux;
                        state                     <= R_ACK;
                    end
                end
                R_ACK:   state <= R_IDLE;
                default: state <= R_IDLE;
            endcase
        end
    end

    // Gated by rst_n so a reset mid-read drops the stall at once.
    assign irq_avalon_slave_waitrequest = rst_n & rd_ok & (state == R_IDLE);

endmodule

// File: tb/tb_usr_irq_slave.sv
// tb_usr_irq_slave: scoreboard bench for usr_irq_slave (CNT_W=8 so the
// saturation boundary is reachable quickly).
module tb_usr_irq_slave;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;
    localparam int TS_W   = 32;
    localparam logic [31:0] CNT_MAX = 32'((1 << CNT_W) - 1);

    logic              clk;
    logic              rst_n;
    logic              cs;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [31:0]       wd;
    logic              waitreq;
    logic [31:0]       rdata;
    logic              irq;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] tb_cyc;
    logic [31:0] last_wr_cyc;
    logic [31:0] ts_exp;

    usr_irq_slave #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .TS_W   (TS_W)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .irq_avalon_slave_chipselect  (cs),
        .irq_avalon_slave_address     (addr),
        .irq_avalon_slave_read        (rd),
        .irq_avalon_slave_write       (wr),
        .irq_avalon_slave_writedata   (wd),
        .irq_avalon_slave_waitrequest (waitreq),
        .irq_avalon_slave_readdata    (rdata),
        .irq_out                      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timer: cycles elapsed since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wd = d;
        last_wr_cyc = tb_cyc;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; wd = '0;
    endtask

    task automatic bus_rd(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [31:0] exp);
        int          waits;
        logic [31:0] e;
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        exp_q.push_back(exp);
        waits = 0;
        #1;
        while (waitreq && waits < 8) begin
            waits++;
            @(negedge clk);
            #1;
        end
        e = exp_q.pop_front();
        check({tag, "_wait"}, 32'(waits), 32'd1);
        check(tag, rdata, e);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic trig();
        bus_wr(ADDR_W'(0), 32'h1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; wd = '0; last_wr_cyc = '0; ts_exp = '0;
        repeat (3) @(negedge clk);
        check("rst_wait", 32'(waitreq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        // Event with interrupt disabled
        trig();
        @(negedge clk);
        check("dis_irq", 32'(irq), 32'd0);
        bus_rd("stat_1", ADDR_W'(1), 32'd1);
        bus_rd("cnt_1", ADDR_W'(3), 32'd1);
        bus_rd("trig_rd", ADDR_W'(0), 32'd1);
        check("dis_irq2", 32'(irq), 32'd0);

        // Enable, trigger, clear: irq latency
        bus_wr(ADDR_W'(1), 32'h3);
        bus_wr(ADDR_W'(2), 32'h1);
        bus_rd("en_rd", ADDR_W'(2), 32'd1);
        trig();
        check("irq_lat0", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'd1);
        bus_wr(ADDR_W'(1), 32'h1);
        check("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_fall", 32'(irq), 32'd0);
        bus_rd("stat_clr", ADDR_W'(1), 32'd0);

        // Overflow and W1C of overflow only
        bus_wr(ADDR_W'(3), 32'h0);
        repeat (3) trig();
        bus_wr(ADDR_W'(0), 32'h2);
        bus_rd("stat_ovf", ADDR_W'(1), 32'd3);
        bus_rd("cnt_3", ADDR_W'(3), 32'd3);
        bus_wr(ADDR_W'(1), 32'h2);
        bus_rd("stat_ovf_clr", ADDR_W'(1), 32'd1);
        bus_wr(ADDR_W'(2), 32'h0);
        @(negedge clk);
        check("irq_disable", 32'(irq), 32'd0);

        // Saturation then clear-then-event
        bus_wr(ADDR_W'(3), 32'h0);
        repeat (int'(CNT_MAX) - 1) trig();
        bus_rd("cnt_max_m1", ADDR_W'(3), CNT_MAX - 32'd1);
        repeat (3) trig();
        bus_rd("cnt_sat", ADDR_W'(3), CNT_MAX);
        bus_wr(ADDR_W'(3), 32'h0);
        trig();
        bus_rd("cnt_after_clr", ADDR_W'(3), 32'd1);

        // Unmapped address, chipselect low, both strobes
        bus_wr(ADDR_W'(1), 32'h3);
        bus_rd("addr7", ADDR_W'(7), 32'd0);
        bus_wr(ADDR_W'(7), 32'hFFFF_FFFF);
        bus_rd("a7_stat", ADDR_W'(1), 32'd0);
        bus_rd("a7_en", ADDR_W'(2), 32'd0);
        bus_rd("a7_cnt", ADDR_W'(3), 32'd1);
        @(negedge clk);
        cs = 1'b0; wr = 1'b1; addr = ADDR_W'(0); wd = 32'h1;
        @(negedge clk);
        wr = 1'b0;
        bus_rd("cs0_stat", ADDR_W'(1), 32'd0);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = ADDR_W'(0); wd = 32'h1;
        #1;
        check("both_wait", 32'(waitreq), 32'd0);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        bus_rd("both_stat", ADDR_W'(1), 32'd0);

        // Timestamp register
        trig();
        ts_exp = last_wr_cyc;
        repeat (49) @(negedge clk);
        trig();
`ifdef USR_IRQ_TIMESTAMP_EN
        bus_rd("ts", ADDR_W'(4), ts_exp);
`else
        bus_rd("ts_absent", ADDR_W'(4), 32'd0);
`endif

        // Reset during the wait cycle of a read
        bus_wr(ADDR_W'(2), 32'h1);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = ADDR_W'(1);
        #1;
        check("mid_wait_hi", 32'(waitreq), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_wait_lo", 32'(waitreq), 32'd0);
        check("mid_rdata", rdata, 32'd0);
        check("mid_irq", 32'(irq), 32'd0);
        cs = 1'b0; rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd("post_stat", ADDR_W'(1), 32'd0);
        bus_rd("post_en", ADDR_W'(2), 32'd0);
        bus_rd("post_cnt", ADDR_W'(3), 32'd0);
        bus_rd("post_ts", ADDR_W'(4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
